// File: rtl/wrptr_full_if.sv
// Write-side FIFO pointer bus: request/clear in, RAM write port and fill status out.
// The master drives requests and the synchronized read pointer; the slave reports status.
interface wrptr_full_if #(
    parameter int ADDRSIZE = 8
);
    logic                wr_en;
    logic                overflow_clr;
    logic [ADDRSIZE:0]   rd_ptr_sync;
    logic [ADDRSIZE-1:0] wr_addr;
    logic                wr_mem_en;
    logic [ADDRSIZE:0]   wr_gray_ptr;
    logic                full;
    logic                almost_full;
    logic [ADDRSIZE:0]   wr_level;
    logic                overflow;

    modport master (
        output wr_en, overflow_clr, rd_ptr_sync,
        input  wr_addr, wr_mem_en, wr_gray_ptr, full, almost_full, wr_level, overflow
    );

    modport slave (
        input  wr_en, overflow_clr, rd_ptr_sync,
        output wr_addr, wr_mem_en, wr_gray_ptr, full, almost_full, wr_level, overflow
    );
endinterface

// File: rtl/wrptr_full.sv
// Async FIFO write pointer and full/almost-full/level/overflow status; flags update on the accepting edge.
// Writes while full are dropped (no strobe) and latch sticky overflow; release of full is pessimistic.
module wrptr_full #(
    parameter int ADDRSIZE     = 8,
    parameter int AFULL_THRESH = 4
) (
    input  logic          wr_clk,
    input  logic          wr_rst,
    wrptr_full_if.slave   bus
);
    localparam int A = ADDRSIZE;
    localparam logic [A:0] DEPTH_V     = {1'b1, {A{1'b0}}};
    localparam logic [A:0] AFULL_LIMIT = DEPTH_V - (A+1)'(AFULL_THRESH);

    logic [A:0] wr_bin;
    logic [A:0] wr_gray;
    logic       full_q;
    logic       afull_q;
    logic [A:0] level_q;
    logic       ovf_q;

    logic       mem_en;
    logic [A:0] wr_bin_next;
    logic [A:0] wr_gray_next;
    logic [A:0] rd_bin_sync;
    logic [A:0] level_next;
    logic [A:0] full_match;
    logic       full_next;

    assign mem_en       = bus.wr_en & ~full_q;
    assign wr_bin_next  = wr_bin + {{A{1'b0}}, mem_en};
    assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);

    // Gray-to-binary: each bit is the XOR of itself and every more-significant bit.
    always_comb begin
        rd_bin_sync = '0;
        for (int i = 0; i <= A; i++) begin
            rd_bin_sync[i] = ^(bus.rd_ptr_sync >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_match = {~bus.rd_ptr_sync[A:A-1], bus.rd_ptr_sync[A-2:0]};
    assign full_next  = (wr_gray_next == full_match);
    assign level_next = wr_bin_next - rd_bin_sync;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wr_bin  <= '0;
            wr_gray <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_bin  <= wr_bin_next;
            wr_gray <= wr_gray_next;
            full_q  <= full_next;
            afull_q <= (level_next >= AFULL_LIMIT);
            level_q <= level_next;
            if (bus.wr_en && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.overflow_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.wr_addr     = wr_bin[A-1:0];
    assign bus.wr_mem_en   = mem_en;
    assign bus.wr_gray_ptr = wr_gray;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.wr_level    = level_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_wrptr_full.sv
// Directed bench for wrptr_full with ADDRSIZE=3 (DEPTH 8), AFULL_THRESH=2.
module tb_wrptr_full;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    wrptr_full_if #(.ADDRSIZE(3)) bus ();

    wrptr_full #(.ADDRSIZE(3), .AFULL_THRESH(2)) dut (
        .wr_clk (clk),
        .wr_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        #2;
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.overflow_clr = 1'b0;
        bus.rd_ptr_sync = 4'b0000;
        #1;
        rst = 1'b0;
    endtask

    logic [3:0] gexp [8];
    logic [3:0] wb;

    initial begin
        gexp = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.overflow_clr = 1'b0;
        bus.rd_ptr_sync = 4'b0000;
        #12;
        chk("rst_gray",  32'(bus.wr_gray_ptr), 32'h0);
        chk("rst_full",  32'(bus.full),        32'h0);
        chk("rst_level", 32'(bus.wr_level),    32'h0);
        chk("rst_ovf",   32'(bus.overflow),    32'h0);
        rst = 1'b0;

        // Async reset after three writes
        cyc();
        bus.wr_en = 1'b1;
        repeat (3) cyc();
        bus.wr_en = 1'b0;
        chk("pre_rst_level", 32'(bus.wr_level),    32'h3);
        chk("pre_rst_gray",  32'(bus.wr_gray_ptr), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gray",  32'(bus.wr_gray_ptr), 32'h0);
        chk("arst_addr",  32'(bus.wr_addr),     32'h0);
        chk("arst_level", 32'(bus.wr_level),    32'h0);
        chk("arst_full",  32'(bus.full),        32'h0);
        chk("arst_af",    32'(bus.almost_full), 32'h0);
        chk("arst_ovf",   32'(bus.overflow),    32'h0);
        rst = 1'b0;

        // Fill with 8 back-to-back writes
        bus.wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("fill_addr", 32'(bus.wr_addr),   32'(i));
            chk("fill_men",  32'(bus.wr_mem_en), 32'h1);
            cyc();
            chk("fill_gray",  32'(bus.wr_gray_ptr), 32'(gexp[i]));
            chk("fill_af",    32'(bus.almost_full), (i >= 5) ? 32'h1 : 32'h0);
            chk("fill_full",  32'(bus.full),        (i == 7) ? 32'h1 : 32'h0);
            chk("fill_level", 32'(bus.wr_level),    32'(i + 1));
        end

        // Overflow: writes held while full are dropped
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ovf_men",  32'(bus.wr_mem_en), 32'h0);
            chk("ovf_addr", 32'(bus.wr_addr),   32'h0);
            cyc();
            chk("ovf_flag",  32'(bus.overflow),    32'h1);
            chk("ovf_level", 32'(bus.wr_level),    32'h8);
            chk("ovf_gray",  32'(bus.wr_gray_ptr), 32'hC);
        end
        bus.wr_en = 1'b0;
        bus.overflow_clr = 1'b1;
        cyc();
        chk("ovf_clr", 32'(bus.overflow), 32'h0);
        bus.wr_en = 1'b1;
        cyc();
        chk("ovf_set_wins", 32'(bus.overflow), 32'h1);
        bus.wr_en = 1'b0;
        bus.overflow_clr = 1'b0;

        // Release: reader has consumed three entries
        bus.rd_ptr_sync = 4'b0010;
        cyc();
        chk("rel_full",  32'(bus.full),        32'h0);
        chk("rel_level", 32'(bus.wr_level),    32'h5);
        chk("rel_af",    32'(bus.almost_full), 32'h0);
        bus.wr_en = 1'b1;
        cyc();
        bus.wr_en = 1'b0;
        chk("rel_level6", 32'(bus.wr_level),    32'h6);
        chk("rel_af6",    32'(bus.almost_full), 32'h1);
        chk("rel_gray",   32'(bus.wr_gray_ptr), 32'hD);

        // Wrap: 20 writes with the read pointer trailing by two
        do_reset();
        wb = 4'h0;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.rd_ptr_sync = gray(wb - 4'd1);
            #1;
            chk("wrap_addr", 32'(bus.wr_addr), 32'(wb[2:0]));
            cyc();
            wb = wb + 4'd1;
            chk("wrap_gray",  32'(bus.wr_gray_ptr), 32'(gray(wb)));
            chk("wrap_level", 32'(bus.wr_level),    32'h2);
            chk("wrap_full",  32'(bus.full),        32'h0);
            if (wb == 4'h0) chk("wrap_gray_zero", 32'(bus.wr_gray_ptr), 32'h0);
        end
        bus.wr_en = 1'b0;

        // Full detected across the pointer wrap
        do_reset();
        bus.wr_en = 1'b1;
        repeat (2) cyc();
        bus.rd_ptr_sync = 4'b1110;
        cyc();
        bus.wr_en = 1'b0;
        chk("xwrap_full",  32'(bus.full),        32'h1);
        chk("xwrap_level", 32'(bus.wr_level),    32'h8);
        chk("xwrap_addr",  32'(bus.wr_addr),     32'h3);
        chk("xwrap_gray",  32'(bus.wr_gray_ptr), 32'h2);
        bus.wr_en = 1'b1;
        #1;
        chk("xwrap_men", 32'(bus.wr_mem_en), 32'h0);
        bus.wr_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wrptr_full.md
# wrptr_full

Write-side pointer and full-flag controller for the asynchronous FIFO; the write-domain counterpart of the read-pointer/empty logic. It keeps the binary write pointer and its registered Gray copy, and drives the dual-port RAM write address and strobe. It compares against the read pointer synchronized into `wr_clk`, and produces the full, almost-full, fill-level and sticky-overflow status. The Gray write pointer it exports is synchronized by the read domain; the incoming `rd_ptr_sync` comes from an external 2-flop synchronizer.

## Interface
- `ADDRSIZE`, 8, RAM address width; depth DEPTH = 2^ADDRSIZE; legal ≥ 2.
- `AFULL_THRESH`, 4, almost-full margin in free slots; legal 1..DEPTH-1.

- `wr_clk` in 1: write clock; all state updates on its rising edge.
- `wr_rst` in 1: reset, asynchronous and active-high. Assertion immediately forces every register to its reset value; release is synchronous to `wr_clk` externally.
- `wr_en` in 1: write request.
- `overflow_clr` in 1: clears sticky `overflow`.
- `rd_ptr_sync` in ADDRSIZE+1: Gray read pointer, already synchronized to `wr_clk`.
- `wr_addr` out ADDRSIZE: RAM write address = `wr_bin[ADDRSIZE-1:0]`.
- `wr_mem_en` out 1: RAM write strobe = `wr_en & ~full` (combinational).
- `wr_gray_ptr` out ADDRSIZE+1: registered Gray write pointer.
- `full` out 1: registered full flag.
- `almost_full` out 1: registered; level ≥ DEPTH - AFULL_THRESH.
- `wr_level` out ADDRSIZE+1: registered occupancy seen in write domain, 0..DEPTH.
- `overflow` out 1: sticky; a write was attempted while `full`.

## Operation
- `wr_bin` (ADDRSIZE+1 bits) is the binary write pointer. `wr_bin_next = wr_bin + wr_mem_en`, with modulo 2^(ADDRSIZE+1) wrap.
- `wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1)`; `wr_gray_ptr <= wr_gray_next`. Only one bit changes per increment, including at wrap.
- Full test: `wr_gray_next == {~rd_ptr_sync[A:A-1], rd_ptr_sync[A-2:0]}` with A = ADDRSIZE; `full <=` result.
- `rd_bin_sync` is the Gray-to-binary conversion of `rd_ptr_sync`: bit i = XOR of bits A..i.
- `level_next = wr_bin_next - rd_bin_sync`, modulo 2^(A+1); `wr_level <= level_next`.
- `almost_full <= (level_next >= DEPTH - AFULL_THRESH)`.
- `overflow`: set when `wr_en & full`; cleared when `overflow_clr` is high. If set and clear occur in the same cycle, set wins.
- A write while `full` is dropped: the pointers hold, `wr_mem_en` = 0, and `overflow` sets.
- Invariant: `full` = 1 exactly when `wr_level` = DEPTH.
- Reset values: `wr_bin` = 0, `wr_gray_ptr` = 0, `wr_addr` = 0, `full` = 0, `almost_full` = 0, `wr_level` = 0, `overflow` = 0.
- Reset mid-operation: all outputs clear immediately without a clock, and any pending write is lost. The read side must be reset in the same event (system requirement).

## Timing
- `wr_mem_en` and `wr_addr` are valid in the cycle of the request. The RAM captures data on that same `wr_clk` edge.
- Pointer, `wr_gray_ptr`, `full`, `almost_full` and `wr_level` all update at the edge that accepts the write. The flags computed from next-state values, so there is zero extra cycle of latency.
- The write that fills the FIFO raises `full` at its own edge, so no write can slip through afterward.
- `full` and `wr_level` release pessimistically. A read becomes visible 2 `wr_clk` cycles after the external sync, plus 1 cycle through this block's registers. They never under-report occupancy.
- `almost_full` rises and falls in the same cycles as the `wr_level` changes that cross the threshold.

## Test plan
All scenarios use ADDRSIZE = 3 (DEPTH 8), AFULL_THRESH = 2, `rd_ptr_sync` = 0 unless stated.
- **Async reset:** raise `wr_rst` between clock edges after 3 writes → all outputs are 0 before the next edge; `wr_gray_ptr` = 4'b0000.
- **Fill:** 8 back-to-back writes → `wr_addr` steps 0..7.
  - `wr_gray_ptr` after each write: 1, 3, 2, 6, 7, 5, 4, C.
  - `almost_full` = 1 from the 6th write; `full` = 1 and `wr_level` = 8 after the 8th.
- **Overflow:** from full, hold `wr_en` 3 cycles → `wr_mem_en` = 0, `wr_addr` stays 0, `overflow` = 1.
  - `overflow_clr` alone → `overflow` = 0.
  - `overflow_clr` together with `wr_en` while full → `overflow` stays 1.
- **Release:** from full, set `rd_ptr_sync` = 4'b0010 (bin 3) → next edge `full` = 0, `wr_level` = 5, `almost_full` = 0. One more write → level 6, `almost_full` = 1.
- **Wrap:** stream 20 writes with `rd_ptr_sync` tracking wr − 2.
  - `wr_bin` wraps 15 → 0 with `wr_gray_ptr` going 8 → 0.
  - `full` never asserts and `wr_level` stays 2.
- **Full across wrap:** `wr_bin` = 4'b0011, `rd_ptr_sync` = gray(4'b1011) = 4'b1110 → `full` = 1, `wr_level` = 8.
